// File: rtl/myo_spi_frame_master_if.sv
// myo_spi_frame_master_if: upstream frame hand-off plus the myocontrol SPI conduit.
// The master modport belongs to the frame engine. The slave modport is its environment.
interface myo_spi_frame_master_if #(
    parameter int NUMBER_OF_MOTORS = 9,
    parameter int FRAME_WORDS = 4,
    parameter int WORD_BITS = 16
);
    logic scan_en;
    logic [FRAME_WORDS*WORD_BITS-1:0] tx_data;
    logic [3:0] motor_sel;
    logic power_sense_n;
    logic [FRAME_WORDS*WORD_BITS-1:0] rx_data;
    logic [3:0] rx_motor;
    logic rx_valid;
    logic busy;
    logic power_fault;
    logic crc_error;
    logic sck;
    logic mosi;
    logic miso;
    logic [NUMBER_OF_MOTORS-1:0] ss_n;
    modport master (
        input scan_en, tx_data, power_sense_n, miso,
        output motor_sel, rx_data, rx_motor, rx_valid, busy, power_fault, crc_error, sck, mosi, ss_n
    );
    modport slave (
        output scan_en, tx_data, power_sense_n, miso,
        input motor_sel, rx_data, rx_motor, rx_valid, busy, power_fault, crc_error, sck, mosi, ss_n
    );
endinterface

// File: rtl/myo_spi_frame_master.sv
// myo_spi_frame_master: round-robin SPI mode-0 frame engine for the myocontrol motor boards.
// Defining MYO_SPI_CHECKSUM_EN appends a checksum word to every frame and flags rx mismatches.
module myo_spi_frame_master #(
    parameter int NUMBER_OF_MOTORS = 9,
    parameter int CLK_DIV = 4,
    parameter int FRAME_WORDS = 4,
    parameter int WORD_BITS = 16,
    parameter int GAP_CYCLES = 8
) (
    input logic clk,
    input logic reset_n,
    myo_spi_frame_master_if.master bus
);
    localparam int DW = FRAME_WORDS * WORD_BITS;
`ifdef MYO_SPI_CHECKSUM_EN
    localparam int NB = DW + WORD_BITS;
`else
    localparam int NB = DW;
`endif
    localparam int BW = $clog2(NB + 1);
    typedef enum logic [2:0] {IDLE, LEAD, XFER_HI, XFER_LO, TRAIL, GAP} state_t;
    state_t state, state_nx;
    logic [15:0] cnt;
    logic [BW-1:0] bit_cnt;
    logic [NB-1:0] tx_sr, rx_sr, tx_load;
    logic [1:0] pwr_sync;
    logic go, phase_done, gap_done, last_bit, frame_end, active;

    assign bus.power_fault = pwr_sync[1];
    assign go = bus.scan_en && !pwr_sync[1];
    assign phase_done = cnt == 16'(CLK_DIV - 1);
    assign gap_done = cnt == 16'(GAP_CYCLES - 1);
    assign last_bit = bit_cnt == BW'(NB - 1);
    assign frame_end = state == TRAIL && phase_done;

`ifdef MYO_SPI_CHECKSUM_EN
    logic [WORD_BITS-1:0] tx_sum, rx_sum;
    logic crc_q;
    always_comb begin
        tx_sum = '0;
        rx_sum = '0;
        for (int i = 0; i < FRAME_WORDS; i++) begin
            tx_sum += bus.tx_data[i*WORD_BITS +: WORD_BITS];
            rx_sum += rx_sr[WORD_BITS + i*WORD_BITS +: WORD_BITS];
        end
    end
    assign tx_load = {bus.tx_data, tx_sum};
    assign bus.crc_error = crc_q;
    always_ff @(posedge clk) begin
        if (!reset_n) crc_q <= 1'b0;
        else if (frame_end) crc_q <= rx_sum != rx_sr[WORD_BITS-1:0];
    end
`else
    assign tx_load = bus.tx_data;
    assign bus.crc_error = 1'b0;
`endif

    always_ff @(posedge clk) state <= !reset_n ? IDLE : state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = go ? LEAD : IDLE;
            LEAD:    state_nx = phase_done ? XFER_HI : LEAD;
            XFER_HI: state_nx = !phase_done ? XFER_HI : last_bit ? TRAIL : XFER_LO;
            XFER_LO: state_nx = phase_done ? XFER_HI : XFER_LO;
            TRAIL:   state_nx = phase_done ? GAP : TRAIL;
            GAP:     state_nx = !gap_done ? GAP : go ? LEAD : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Pins decode straight from the state register, so they switch on state entry.
    always_comb begin
        active = state inside {LEAD, XFER_HI, XFER_LO, TRAIL};
        bus.busy = active;
        bus.sck = state == XFER_HI;
        bus.mosi = active && tx_sr[NB-1];
        bus.ss_n = active ? ~(NUMBER_OF_MOTORS'(1) << bus.motor_sel) : '1;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pwr_sync <= '1;
            cnt <= '0;
            bit_cnt <= '0;
            tx_sr <= '0;
            rx_sr <= '0;
            bus.rx_valid <= 1'b0;
            bus.rx_data <= '0;
            bus.rx_motor <= '0;
            bus.motor_sel <= '0;
        end else begin
            pwr_sync <= {pwr_sync[0], bus.power_sense_n};
            cnt <= state_nx != state ? 16'd0 : cnt + 16'd1;
            bus.rx_valid <= frame_end;
            if (state_nx == LEAD && state != LEAD) begin
                tx_sr <= tx_load;
                bit_cnt <= '0;
            end
            if (state == XFER_HI && state_nx == XFER_LO) begin
                tx_sr <= tx_sr << 1;
                bit_cnt <= bit_cnt + BW'(1);
            end
            if (state_nx == XFER_HI && state != XFER_HI) rx_sr <= {rx_sr[NB-2:0], bus.miso};
            if (frame_end) begin
                bus.rx_data <= rx_sr[NB-1 -: DW];
                bus.rx_motor <= bus.motor_sel;
                bus.motor_sel <= bus.motor_sel == 4'(NUMBER_OF_MOTORS - 1) ? 4'd0 : bus.motor_sel + 4'd1;
            end
        end
    end
endmodule
